branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 128 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction queue: records {index, pred} at fetch, retires in order on resolve,
// and emits a registered predictor-update strobe. Optional perf counters: define BRQ_PERF_CNT_EN.
module branch_resolve_queue #(
  parameter int index      = 3,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [index-1:0] push_index,
  input  logic             push_pred,
  output logic             full,
  output logic             empty,
  input  logic             resolve,
  input  logic             actual_taken,
  input  logic             flush,
  output logic             update_history,
  output logic             br_result,
  output logic [index-1:0] uindex,
  output logic             mispredict,
  output logic             underflow,
  output logic [31:0]      total_cnt,
  output logic [31:0]      correct_cnt,
  output logic [31:0]      wrong_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [index:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [DEPTH_LOG2:0]   r_count;

  logic [index-1:0]      w_head_index;
  logic                  w_head_pred;
  logic                  w_res_acc;
  logic                  w_mis;
  logic                  w_push_acc;
  logic [DEPTH_LOG2:0]   w_count_nxt;

  assign full  = (r_count == CNT_FULL);
  assign empty = (r_count == '0);

  assign w_head_index = r_mem[r_head][index:1];
  assign w_head_pred  = r_mem[r_head][0];

  // flush beats resolve beats push; a mispredict makes any same-cycle push wrong-path
  assign w_res_acc  = resolve & ~empty & ~flush;
  assign w_mis      = w_res_acc & (actual_taken != w_head_pred);
  assign w_push_acc = push & ~flush & ~w_mis & (~full | w_res_acc);

  always_comb begin
    w_count_nxt = r_count;
    if (flush || w_mis)
      w_count_nxt = '0;
    else if (w_push_acc && !w_res_acc)
      w_count_nxt = r_count + 1'b1;
    else if (!w_push_acc && w_res_acc)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      update_history <= 1'b0;
      br_result      <= 1'b0;
      uindex         <= '0;
      mispredict     <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      r_count        <= w_count_nxt;
      update_history <= w_res_acc;
      br_result      <= w_res_acc & actual_taken;
      uindex         <= w_res_acc ? w_head_index : '0;
      mispredict     <= w_mis;
      if (resolve && empty && !flush)
        underflow <= 1'b1;
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_res_acc)
          r_head <= r_head + 1'b1;
        if (w_mis)
          r_tail <= r_head + 1'b1;
        else if (w_push_acc)
          r_tail <= r_tail + 1'b1;
      end
    end
  end

  // entry payload carries no reset; validity is defined by head/count
  always_ff @(posedge clk) begin
    if (w_push_acc)
      r_mem[r_tail] <= {push_index, push_pred};
  end

`ifdef BRQ_PERF_CNT_EN
  logic [31:0] r_total;
  logic [31:0] r_correct;
  logic [31:0] r_wrong;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total   <= '0;
      r_correct <= '0;
      r_wrong   <= '0;
    end else if (w_res_acc) begin
      r_total <= r_total + 32'd1;
      if (w_mis)
        r_wrong <= r_wrong + 32'd1;
      else
        r_correct <= r_correct + 32'd1;
    end
  end

  assign total_cnt   = r_total;
  assign correct_cnt = r_correct;
  assign wrong_cnt   = r_wrong;
`else
  assign total_cnt   = 32'd0;
  assign correct_cnt = 32'd0;
  assign wrong_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int IW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic [IW-1:0] push_index = '0;
  logic          push_pred = 1'b0;
  logic          resolve = 1'b0;
  logic          actual_taken = 1'b0;
  logic          flush = 1'b0;
  logic          full, empty, update_history, br_result, mispredict, underflow;
  logic [IW-1:0] uindex;
  logic [31:0]   total_cnt, correct_cnt, wrong_cnt;

  branch_resolve_queue #(.index(IW), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .push(push), .push_index(push_index), .push_pred(push_pred),
    .full(full), .empty(empty), .resolve(resolve), .actual_taken(actual_taken),
    .flush(flush), .update_history(update_history), .br_result(br_result),
    .uindex(uindex), .mispredict(mispredict), .underflow(underflow),
    .total_cnt(total_cnt), .correct_cnt(correct_cnt), .wrong_cnt(wrong_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] idx; logic pred; } ent_t;
  typedef struct { logic [IW-1:0] idx; logic taken; logic mis; int due; } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic m_under = 1'b0;
  int   m_total = 0, m_correct = 0, m_wrong = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation, due exactly one cycle after resolve
  always @(negedge clk) begin
    if (!rst) begin
      if (update_history) begin
        if (exp_q.size() == 0) begin
          chk("spurious_update", 32'(update_history), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("upd_latency", 32'(cyc), 32'(e.due));
          chk("uindex", 32'(uindex), 32'(e.idx));
          chk("br_result", 32'(br_result), 32'(e.taken));
          chk("mispredict", 32'(mispredict), 32'(e.mis));
        end
      end else begin
        chk("idle_outputs_zero", {28'd0, br_result, mispredict, uindex == '0 ? 1'b0 : 1'b1, 1'b0}, 32'd0);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("missing_update", 32'(update_history), 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_state();
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("underflow", 32'(underflow), 32'(m_under));
  endtask

  // One cycle: compare state, drive inputs, advance the model, then cross the clock edge.
  task automatic step(input logic p, input logic [IW-1:0] pi, input logic pp,
                      input logic r, input logic a, input logic f);
    logic was_full, res_ok, mis;
    check_state();
    push = p; push_index = pi; push_pred = pp;
    resolve = r; actual_taken = a; flush = f;
    if (f) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      res_ok   = r && (mq.size() > 0);
      mis      = 1'b0;
      if (r && mq.size() == 0) m_under = 1'b1;
      if (res_ok) begin
        ent_t h;
        exp_t e;
        h = mq.pop_front();
        mis = (a != h.pred);
        e.idx = h.idx; e.taken = a; e.mis = mis; e.due = cyc + 1;
        exp_q.push_back(e);
        m_total++;
        if (mis) m_wrong++; else m_correct++;
      end
      if (mis) begin
        mq.delete();
      end else if (p && (!was_full || res_ok)) begin
        ent_t n;
        n.idx = pi; n.pred = pp;
        mq.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    push = 1'b0; resolve = 1'b0; flush = 1'b0;
  endtask

  task automatic check_counters();
`ifdef BRQ_PERF_CNT_EN
    chk("total_cnt", total_cnt, 32'(m_total));
    chk("correct_cnt", correct_cnt, 32'(m_correct));
    chk("wrong_cnt", wrong_cnt, 32'(m_wrong));
`else
    chk("total_cnt_off", total_cnt, 32'd0);
    chk("correct_cnt_off", correct_cnt, 32'd0);
    chk("wrong_cnt_off", wrong_cnt, 32'd0);
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_under = 1'b0;
    m_total = 0; m_correct = 0; m_wrong = 0;
  endtask

  initial begin
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_update", 32'(update_history), 32'd0);
    chk("rst_uindex", 32'(uindex), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // single push/resolve taken
    step(1, 3'd5, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // fill, overflow drop, drain in order
    for (int i = 1; i <= 4; i++) step(1, 3'(i), 0, 0, 0, 0);
    step(1, 3'd7, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // mispredict flushes younger entries and drops the same-cycle push
    step(1, 3'd1, 1, 0, 0, 0);
    step(1, 3'd2, 0, 0, 0, 0);
    step(1, 3'd3, 0, 0, 0, 0);
    step(1, 3'd4, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // full queue: push with correct resolve is accepted
    for (int i = 1; i <= 4; i++) step(1, 3'(i), 0, 0, 0, 0);
    step(1, 3'd6, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);

    // underflow sticks, flush empties
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 3'(i), 1, 0, 0, 0);
    step(1, 3'd7, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    // async reset mid-operation, then 3 correct + 1 wrong for the counters
    step(1, 3'd2, 1, 0, 0, 0);
    step(1, 3'd3, 1, 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_update", 32'(update_history), 32'd0);
    chk("async_rst_underflow", 32'(underflow), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 3'(i), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_counters();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_counters();
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
